fm_hop_sequencer: RTL and testbench
===================================

# fm_hop_sequencer

Wishbone master that drives the FM generator's register slave to produce frequency-hopped or stepped-sweep FM. On start it writes the modulation frequency and deviation registers once, then rewrites the carrier center increment every dwell period, stepping by a signed increment for a programmed number of hops. It optionally loops. It sits between the host control logic and the FM generator slave, and is the only master on that bus.

## Interface
- TIMEOUT_CYCLES, 16, max cycles from strobe to ack before a write is abandoned
- DWELL_WIDTH, 24, width of dwell counter
- HOP_WIDTH, 16, width of hop count/index
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle start request, honoured only in IDLE
- i_stop  in  1  one-cycle stop request
- i_cfg_start_inc  in  31  first carrier increment
- i_cfg_step  in  31  signed per-hop carrier step
- i_cfg_hops  in  HOP_WIDTH  number of carrier writes per pass
- i_cfg_dwell  in  DWELL_WIDTH  cycles between end of one carrier write and start of next
- i_cfg_loop  in  1  restart at hop 0 after last hop
- i_cfg_mod_inc  in  31  modulation increment (register 1)
- i_cfg_dev  in  17  deviation amount (register 2)
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master controls
- o_wb_addr  out  2  register address
- o_wb_data  out  32  write data
- i_wb_ack, i_wb_stall  in  1 each  slave responses
- o_busy  out  1  high in any state but IDLE
- o_hop_index  out  HOP_WIDTH  index of last carrier write acked
- o_done  out  1  one-cycle pulse on normal completion or stop
- o_err  out  1  one-cycle pulse on ack timeout

## Operation
- States: IDLE, WR_MOD, WR_DEV, WR_CAR, DWELL.
- On i_start in IDLE, all i_cfg_* inputs are latched. Later config changes are ignored until the next start.
- Transitions: IDLE→WR_MOD→WR_DEV→WR_CAR→DWELL→WR_CAR…
- WR_MOD writes addr 1, data {1'b0,mod_inc}. WR_DEV writes addr 2, data {15'b0,dev}. WR_CAR writes addr 0, data {1'b0,carrier}.
- Write handshake in every WR_* state:
  - cyc, stb and we assert together.
  - stb drops after the first cycle in which stall=0.
  - cyc holds until ack, then drops in the same cycle the state advances.
  - Only one write is outstanding at a time.
- Carrier accumulator:
  - Loaded with start_inc at start.
  - After each acked carrier write: carrier += step, 31-bit modular wrap, no saturation.
  - o_hop_index updates on that ack.
- After the carrier ack, if hops written == i_cfg_hops:
  - loop=0 → IDLE with o_done.
  - loop=1 → carrier reloads start_inc, index restarts, DWELL.
  - Otherwise → DWELL.
- hops=0: config writes only, then IDLE with o_done.
- DWELL lasts exactly max(dwell,1) cycles.
- i_stop:
  - In DWELL: → IDLE next cycle, o_done.
  - In a WR_* state: the current write completes, then → IDLE with o_done. The stop is remembered.
  - Ignored in IDLE.
- Timeout: if ack is absent TIMEOUT_CYCLES cycles after stb first asserted, the block drops cyc/stb, returns to IDLE and pulses o_err (no o_done).
- i_start while busy is ignored.

## Timing
- Reset values:
  - all Wishbone outputs 0, o_busy 0, o_hop_index 0, o_done 0, o_err 0, state IDLE, counters 0.
  - Reset mid-write drops cyc/stb asynchronously.
- stb rises the cycle after i_start is sampled.
- With a zero-stall slave acking one cycle after stb, each write takes 2 cycles (stb cycle, ack cycle).
- Start→first carrier stb = 5 cycles.
- Carrier write period = dwell+2 cycles.
- o_done and o_err assert the cycle after the terminating event.
- o_busy falls in the same cycle o_done/o_err rise.

## Structure
- Package fm_ctrl_pkg holds:
  - register address constants REG_CARRIER=0, REG_MOD=1, REG_DEV=2;
  - state enum;
  - the 31-bit increment width constant.
- Sub-module wb_single_writer: one-write Wishbone engine (req/addr/data in; done/timeout out; owns stb/cyc drop rules and the timeout counter). The sequencer FSM instantiates it once.

## Test plan
- Sweep, zero-stall ack-next-cycle slave: start_inc=0x444444, step=0x1000, hops=3, dwell=4, loop=0 → writes addr1, addr2, then addr0 = 0x444444, 0x445444, 0x446444 spaced 6 cycles; o_done once; o_hop_index ends 2.
- Wrap: start_inc=0x7FFFFFF0, step=0x20, hops=2 → second carrier data 0x00000010.
- Stall: slave holds stall=1 for 3 cycles → stb stays high 4 cycles, one ack, no duplicate write.
- Timeout: slave never acks → cyc drops after 16 cycles, o_err pulses once, o_busy=0, o_done stays 0.
- Stop mid-write: i_stop during an addr0 stb → that write acks, no further writes, o_done pulses. Stop in DWELL → IDLE next cycle.
- Loop and reset: loop=1, hops=2 → carrier data cycles A, A+s, A, A+s… and no config rewrites; async reset mid-stb → all outputs 0 immediately.

Source files
------------

// File: rtl/fm_ctrl_pkg.sv
// Shared constants and state encoding for the FM hop sequencer and its
// Wishbone write engine.
package fm_ctrl_pkg;

    localparam int INC_WIDTH = 31;

    localparam logic [1:0] REG_CARRIER = 2'd0;
    localparam logic [1:0] REG_MOD     = 2'd1;
    localparam logic [1:0] REG_DEV     = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MOD,
        ST_WR_DEV,
        ST_WR_CAR,
        ST_DWELL
    } hop_state_t;

endpackage

// File: rtl/fm_hop_sequencer_if.sv
// Pipelined Wishbone write-only link between the hop sequencer and the
// FM generator register slave.
interface fm_hop_sequencer_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        ack;
    logic        stall;

    modport master (output cyc, stb, we, addr, data, input ack, stall);
    modport slave  (input cyc, stb, we, addr, data, output ack, stall);
endinterface

// File: rtl/wb_single_writer.sv
// Single-outstanding Wishbone write engine: holds cyc while req is high,
// issues stb once until accepted, and abandons the write on ack timeout.
module wb_single_writer
    import fm_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                req,
    input  logic [1:0]          addr,
    input  logic [31:0]         data,
    fm_hop_sequencer_if.master  wb,
    output logic                done,
    output logic                timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          sent;
    logic [TW-1:0] elapsed;

    // Bus outputs decode straight from req so a reset of the owning FSM
    // drops cyc/stb without waiting for a clock edge.
    assign wb.cyc  = req;
    assign wb.stb  = req & ~sent;
    assign wb.we   = req;
    assign wb.addr = req ? addr : 2'd0;
    assign wb.data = req ? data : 32'd0;

    assign done    = req & wb.ack;
    assign timeout = req & ~wb.ack & (elapsed == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sent    <= 1'b0;
            elapsed <= '0;
        end else if (!req || done || timeout) begin
            sent    <= 1'b0;
            elapsed <= '0;
        end else begin
            if (wb.stb && !wb.stall)
                sent <= 1'b1;
            elapsed <= elapsed + TW'(1);
        end
    end

endmodule

// File: rtl/fm_hop_sequencer.sv
// Wishbone master that programs the FM generator once, then rewrites the
// carrier increment every dwell period for a stepped sweep or hop pattern.
//
// state     | meaning
// ST_IDLE   | waiting for i_start, config latched on start
// ST_WR_MOD | writing modulation increment (reg 1)
// ST_WR_DEV | writing deviation (reg 2)
// ST_WR_CAR | writing carrier increment (reg 0)
// ST_DWELL  | holding the current carrier for max(dwell,1) cycles
module fm_hop_sequencer
    import fm_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DWELL_WIDTH    = 24,
    parameter int HOP_WIDTH      = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [INC_WIDTH-1:0]   i_cfg_start_inc,
    input  logic [INC_WIDTH-1:0]   i_cfg_step,
    input  logic [HOP_WIDTH-1:0]   i_cfg_hops,
    input  logic [DWELL_WIDTH-1:0] i_cfg_dwell,
    input  logic                   i_cfg_loop,
    input  logic [INC_WIDTH-1:0]   i_cfg_mod_inc,
    input  logic [16:0]            i_cfg_dev,
    fm_hop_sequencer_if.master     wb,
    output logic                   o_busy,
    output logic [HOP_WIDTH-1:0]   o_hop_index,
    output logic                   o_done,
    output logic                   o_err
);

    hop_state_t state, state_n;

    logic [INC_WIDTH-1:0]   start_inc_q, step_q, mod_q, carrier;
    logic [HOP_WIDTH-1:0]   hops_q, hop_cnt, hop_nxt;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_cnt, dwell_load;
    logic [16:0]            dev_q;
    logic                   loop_q, stop_pend, stop_now, hop_last;
    logic                   wr_req, wr_done, wr_timeout, car_ack, done_n, err_n;
    logic [1:0]             wr_addr;
    logic [31:0]            wr_data;

    assign hop_nxt    = hop_cnt + HOP_WIDTH'(1);
    assign hop_last   = (hop_nxt == hops_q);
    assign dwell_load = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);
    assign stop_now   = stop_pend | i_stop;
    assign o_busy     = (state != ST_IDLE);

    wb_single_writer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_writer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .req     (wr_req),
        .addr    (wr_addr),
        .data    (wr_data),
        .wb      (wb),
        .done    (wr_done),
        .timeout (wr_timeout)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        err_n   = 1'b0;
        wr_req  = 1'b0;
        wr_addr = REG_CARRIER;
        wr_data = 32'd0;
        car_ack = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start)
                    state_n = ST_WR_MOD;
            end
            ST_WR_MOD: begin
                wr_req  = 1'b1;
                wr_addr = REG_MOD;
                wr_data = {1'b0, mod_q};
                if (wr_timeout) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end else if (wr_done) begin
                    if (stop_now) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_WR_DEV;
                    end
                end
            end
            ST_WR_DEV: begin
                wr_req  = 1'b1;
                wr_addr = REG_DEV;
                wr_data = {15'd0, dev_q};
                if (wr_timeout) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end else if (wr_done) begin
                    if (stop_now || hops_q == '0) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_WR_CAR;
                    end
                end
            end
            ST_WR_CAR: begin
                wr_req  = 1'b1;
                wr_addr = REG_CARRIER;
                wr_data = {1'b0, carrier};
                if (wr_timeout) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end else if (wr_done) begin
                    car_ack = 1'b1;
                    if (stop_now || (hop_last && !loop_q)) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_DWELL;
                    end
                end
            end
            ST_DWELL: begin
                if (i_stop) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else if (dwell_cnt == '0) begin
                    state_n = ST_WR_CAR;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            start_inc_q <= '0;
            step_q      <= '0;
            mod_q       <= '0;
            dev_q       <= '0;
            hops_q      <= '0;
            dwell_q     <= '0;
            loop_q      <= 1'b0;
            carrier     <= '0;
            hop_cnt     <= '0;
            dwell_cnt   <= '0;
            stop_pend   <= 1'b0;
            o_hop_index <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_done <= done_n;
            o_err  <= err_n;

            if (state == ST_IDLE && i_start) begin
                start_inc_q <= i_cfg_start_inc;
                step_q      <= i_cfg_step;
                mod_q       <= i_cfg_mod_inc;
                dev_q       <= i_cfg_dev;
                hops_q      <= i_cfg_hops;
                dwell_q     <= i_cfg_dwell;
                loop_q      <= i_cfg_loop;
                carrier     <= i_cfg_start_inc;
                hop_cnt     <= '0;
            end else if (car_ack) begin
                o_hop_index <= hop_cnt;
                dwell_cnt   <= dwell_load;
                if (hop_last) begin
                    carrier <= start_inc_q;
                    hop_cnt <= '0;
                end else begin
                    carrier <= carrier + step_q;
                    hop_cnt <= hop_nxt;
                end
            end else if (state == ST_DWELL && dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
            end

            // A stop seen mid-write is held until that write finishes.
            if (state_n == ST_IDLE)
                stop_pend <= 1'b0;
            else if (i_stop && wr_req)
                stop_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fm_hop_sequencer.sv
// Self-checking bench for fm_hop_sequencer: a behavioural Wishbone slave
// pops expected writes from a scoreboard queue as each write is accepted.
module tb_fm_hop_sequencer;
    import fm_ctrl_pkg::*;

    localparam int HW = 16;
    localparam int DW = 24;
    localparam logic [30:0] MOD_V = 31'h0123_4567;
    localparam logic [16:0] DEV_V = 17'h1_ABCD;

    logic          i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_stop = 1'b0;
    logic [30:0]   cfg_start_inc = '0, cfg_step = '0, cfg_mod_inc = MOD_V;
    logic [HW-1:0] cfg_hops = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          cfg_loop = 1'b0;
    logic [16:0]   cfg_dev = DEV_V;
    logic          o_busy, o_done, o_err;
    logic [HW-1:0] o_hop_index;

    fm_hop_sequencer_if wb();

    fm_hop_sequencer #(.TIMEOUT_CYCLES(16), .DWELL_WIDTH(DW), .HOP_WIDTH(HW)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .i_cfg_start_inc (cfg_start_inc),
        .i_cfg_step      (cfg_step),
        .i_cfg_hops      (cfg_hops),
        .i_cfg_dwell     (cfg_dwell),
        .i_cfg_loop      (cfg_loop),
        .i_cfg_mod_inc   (cfg_mod_inc),
        .i_cfg_dev       (cfg_dev),
        .wb              (wb),
        .o_busy          (o_busy),
        .o_hop_index     (o_hop_index),
        .o_done          (o_done),
        .o_err           (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   acc_log[$];
    int   cnt = 0, checks = 0, failures = 0;
    int   stall_cfg = 0, stall_left = 0;
    bit   no_ack = 1'b0, pend = 1'b0;
    int   done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
    int   stb_cycles = 0, cyc_cycles = 0, start_cyc = 0, stop_cyc = 0;
    int   d0, e0;
    logic busy_at_done = 1'b0, busy_at_err = 1'b0;

    always @(posedge i_clk) cnt <= cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave: stalls stall_cfg cycles per write, acks the cycle after accept.
    always @(negedge i_clk) begin
        if (i_reset) begin
            wb.ack     = 1'b0;
            wb.stall   = 1'b0;
            pend       = 1'b0;
            stall_left = stall_cfg;
        end else begin
            wb.ack = pend;
            pend   = 1'b0;
            if (wb.stb) begin
                if (stall_left > 0) begin
                    wb.stall = 1'b1;
                    stall_left--;
                end else begin
                    wb.stall = 1'b0;
                    acc_log.push_back(cnt);
                    chk("wr_expected", exp_q.size() != 0, 1);
                    chk("wr_we", wb.we, 1);
                    if (exp_q.size() != 0) begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", wb.addr, e.addr);
                        chk("wr_data", wb.data, e.data);
                    end
                    pend       = !no_ack;
                    stall_left = stall_cfg;
                end
            end else begin
                wb.stall = 1'b0;
            end
            if (wb.stb) stb_cycles++;
            if (wb.cyc) cyc_cycles++;
            if (o_done) begin
                done_cnt++;
                done_cyc     = cnt;
                busy_at_done = o_busy;
            end
            if (o_err) begin
                err_cnt++;
                err_cyc     = cnt;
                busy_at_err = o_busy;
            end
        end
    end

    task automatic push_exp(input logic [1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_cfg_writes();
        push_exp(REG_MOD, {1'b0, MOD_V});
        push_exp(REG_DEV, {15'd0, DEV_V});
    endtask

    task automatic set_cfg(input logic [30:0] s, input logic [30:0] st, input int hops,
                           input int dwell, input logic lp);
        @(negedge i_clk);
        cfg_start_inc = s;
        cfg_step      = st;
        cfg_hops      = HW'(hops);
        cfg_dwell     = DW'(dwell);
        cfg_loop      = lp;
        cfg_mod_inc   = MOD_V;
        cfg_dev       = DEV_V;
        acc_log.delete();
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start   = 1'b1;
        start_cyc = cnt;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!o_done && !o_err && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (!(o_done || o_err)) chk({tag, "_end_timeout"}, 0, 1);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic wait_dwell(input string tag, input int budget);
        int n = 0;
        while (!(o_busy && !wb.cyc) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (!(o_busy && !wb.cyc)) chk({tag, "_dwell_timeout"}, 0, 1);
    endtask

    task automatic wait_acc(input string tag, input int n_wr, input int budget);
        int n = 0;
        while (acc_log.size() < n_wr && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (acc_log.size() < n_wr) chk({tag, "_acc_timeout"}, acc_log.size(), n_wr);
    endtask

    task automatic stop_pulse();
        i_stop   = 1'b1;
        stop_cyc = cnt;
        @(negedge i_clk);
        i_stop = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        chk("rst_cyc", wb.cyc, 0);
        chk("rst_stb", wb.stb, 0);
        chk("rst_we", wb.we, 0);
        chk("rst_addr", wb.addr, 0);
        chk("rst_data", wb.data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_idx", o_hop_index, 0);
        chk("rst_done_err", {o_done, o_err}, 0);
        i_reset = 1'b0;

        // Sweep with timing checks.
        set_cfg(31'h444444, 31'h1000, 3, 4, 1'b0);
        push_cfg_writes();
        push_exp(REG_CARRIER, 32'h444444);
        push_exp(REG_CARRIER, 32'h445444);
        push_exp(REG_CARRIER, 32'h446444);
        pulse_start();
        wait_end("sweep", 200);
        chk("sweep_drained", exp_q.size(), 0);
        chk("sweep_nwr", acc_log.size(), 5);
        if (acc_log.size() == 5) begin
            chk("sweep_first_stb", acc_log[0] - start_cyc, 1);
            chk("sweep_first_car", acc_log[2] - start_cyc, 5);
            chk("sweep_period_a", acc_log[3] - acc_log[2], 6);
            chk("sweep_period_b", acc_log[4] - acc_log[3], 6);
            chk("sweep_done_lat", done_cyc - acc_log[4], 2);
        end
        chk("sweep_done_cnt", done_cnt - d0, 1);
        chk("sweep_err_cnt", err_cnt - e0, 0);
        chk("sweep_idx", o_hop_index, 2);
        chk("sweep_busy_at_done", busy_at_done, 0);

        // Wrap, and a start while busy must be ignored.
        set_cfg(31'h7FFF_FFF0, 31'h20, 2, 3, 1'b0);
        push_cfg_writes();
        push_exp(REG_CARRIER, 32'h7FFF_FFF0);
        push_exp(REG_CARRIER, 32'h0000_0010);
        pulse_start();
        wait_acc("wrap", 3, 100);
        pulse_start();
        wait_end("wrap", 200);
        chk("wrap_drained", exp_q.size(), 0);
        chk("wrap_nwr", acc_log.size(), 4);
        chk("wrap_done_cnt", done_cnt - d0, 1);

        // Stall for 3 cycles on every write.
        stall_cfg  = 3;
        stall_left = 3;
        set_cfg(31'h1000, 31'h1, 1, 2, 1'b0);
        push_cfg_writes();
        push_exp(REG_CARRIER, 32'h1000);
        stb_cycles = 0;
        pulse_start();
        wait_end("stall", 200);
        chk("stall_stb_cycles", stb_cycles, 12);
        chk("stall_nwr", acc_log.size(), 3);
        chk("stall_drained", exp_q.size(), 0);
        stall_cfg  = 0;
        stall_left = 0;

        // hops = 0: configuration writes only.
        set_cfg(31'h2222, 31'h1, 0, 2, 1'b0);
        push_cfg_writes();
        pulse_start();
        wait_end("hops0", 100);
        chk("hops0_nwr", acc_log.size(), 2);
        if (acc_log.size() == 2) chk("hops0_done_lat", done_cyc - acc_log[1], 2);
        chk("hops0_done_cnt", done_cnt - d0, 1);

        // Ack timeout.
        no_ack = 1'b1;
        set_cfg(31'h3333, 31'h1, 1, 2, 1'b0);
        push_exp(REG_MOD, {1'b0, MOD_V});
        cyc_cycles = 0;
        pulse_start();
        wait_end("tmo", 100);
        chk("tmo_err_cnt", err_cnt - e0, 1);
        chk("tmo_done_cnt", done_cnt - d0, 0);
        chk("tmo_cyc_cycles", cyc_cycles, 16);
        chk("tmo_err_lat", err_cyc - start_cyc, 17);
        chk("tmo_busy_at_err", busy_at_err, 0);
        chk("tmo_busy", o_busy, 0);
        no_ack = 1'b0;
        repeat (3) @(negedge i_clk);

        // Stop during the first carrier strobe.
        set_cfg(31'h2000, 31'h100, 5, 3, 1'b0);
        push_cfg_writes();
        push_exp(REG_CARRIER, 32'h2000);
        pulse_start();
        begin
            int n = 0;
            while (!(wb.stb && wb.addr == REG_CARRIER) && n < 50) begin
                @(negedge i_clk);
                n++;
            end
        end
        stop_pulse();
        wait_end("stopwr", 100);
        repeat (20) @(negedge i_clk);
        chk("stopwr_nwr", acc_log.size(), 3);
        chk("stopwr_drained", exp_q.size(), 0);
        chk("stopwr_done_cnt", done_cnt - d0, 1);
        if (acc_log.size() == 3) chk("stopwr_done_lat", done_cyc - acc_log[2], 2);

        // Stop in DWELL.
        set_cfg(31'h3000, 31'h100, 5, 10, 1'b0);
        push_cfg_writes();
        push_exp(REG_CARRIER, 32'h3000);
        pulse_start();
        wait_dwell("stopdw", 50);
        stop_pulse();
        wait_end("stopdw", 20);
        chk("stopdw_done_lat", done_cyc - stop_cyc, 1);
        chk("stopdw_busy_at_done", busy_at_done, 0);
        chk("stopdw_nwr", acc_log.size(), 3);

        // Loop with config inputs changed after start.
        set_cfg(31'h100, 31'h10, 2, 2, 1'b1);
        push_cfg_writes();
        for (int i = 0; i < 3; i++) begin
            push_exp(REG_CARRIER, 32'h100);
            push_exp(REG_CARRIER, 32'h110);
        end
        pulse_start();
        cfg_start_inc = 31'h5_5555;
        cfg_step      = 31'h7;
        cfg_hops      = HW'(9);
        cfg_loop      = 1'b0;
        wait_acc("loop", 8, 300);
        wait_dwell("loop", 20);
        stop_pulse();
        wait_end("loop", 20);
        chk("loop_nwr", acc_log.size(), 8);
        chk("loop_drained", exp_q.size(), 0);
        chk("loop_idx", o_hop_index, 1);
        chk("loop_done_cnt", done_cnt - d0, 1);

        // Asynchronous reset while strobing.
        set_cfg(31'h4000, 31'h1, 1, 1, 1'b0);
        push_exp(REG_MOD, {1'b0, MOD_V});
        pulse_start();
        #1 i_reset = 1'b1;
        #1;
        chk("arst_cyc", wb.cyc, 0);
        chk("arst_stb", wb.stb, 0);
        chk("arst_we", wb.we, 0);
        chk("arst_addr_data", {wb.addr, wb.data[29:0]}, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_idx", o_hop_index, 0);
        chk("arst_done_err", {o_done, o_err}, 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        chk("arst_after_busy", o_busy, 0);
        chk("arst_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
